// File: rtl/uart_rx_word_ctrl.sv
// UART receive word assembler: gathers WORD_BYTES bytes from RxDone edges and offers them on WordValid/WordReady.
// Word valid 1 Clk after the last byte edge; a held word blocks capture, and new bytes in that state raise Overrun.
// Optional inter-byte timeout behind `UART_RX_WORD_TIMEOUT_EN (off: Timeout tied low, no counter).
module uart_rx_word_ctrl #(
   parameter int unsigned WORD_BYTES    = 4,
   parameter logic [15:0] TIMEOUT_TICKS = 16'd640
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      Enable,
   input  logic                      ClrErr,
   input  logic                      Tick,
   input  logic                      RxDone,
   input  logic [7:0]                RxData,
   output logic                      RxEn,
   output logic [3:0]                NBits,
   output logic [8*WORD_BYTES-1:0]   WordData,
   output logic                      WordValid,
   input  logic                      WordReady,
   output logic                      Overrun,
   output logic                      Timeout,
   output logic [3:0]                ByteCnt
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              byte_cnt_q, byte_cnt_d;
   logic [8*WORD_BYTES-1:0] word_q, word_d;
   logic                    overrun_q, overrun_d;
   logic                    rxen_q, rxen_d;
   logic                    rxdone_q, rxdone_d;
   logic                    done_evt, accept, overrun_evt, timeout_evt;

   assign done_evt = RxDone & ~rxdone_q;
   assign accept   = (state_q == S_HOLD) & WordReady;

`ifdef UART_RX_WORD_TIMEOUT_EN
   logic        tick_q, tick_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic        timeout_q, timeout_d;
   logic        tick_rise;

   assign tick_rise = Tick & ~tick_q;
   // A byte landing on the terminal tick wins over the timeout.
   assign timeout_evt = (state_q == S_COLLECT) & Enable & (byte_cnt_q != 4'd0) & ~done_evt
                        & tick_rise & (tick_cnt_q == TIMEOUT_TICKS - 16'd1);

   always_comb begin
      tick_d     = Tick;
      tick_cnt_d = tick_cnt_q;
      timeout_d  = (timeout_q & ~ClrErr) | timeout_evt;
      if ((state_q != S_COLLECT) || (byte_cnt_q == 4'd0) || done_evt || timeout_evt) begin
         tick_cnt_d = 16'd0;
      end else if (tick_rise) begin
         tick_cnt_d = tick_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         tick_q     <= 1'b0;
         tick_cnt_q <= 16'd0;
         timeout_q  <= 1'b0;
      end else begin
         tick_q     <= tick_d;
         tick_cnt_q <= tick_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign Timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^{Tick, TIMEOUT_TICKS};
   assign timeout_evt = 1'b0;
   assign Timeout     = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_d      = word_q;
      overrun_evt = 1'b0;
      rxen_d      = Enable;
      rxdone_d    = RxDone;
      case (state_q)
         S_IDLE: begin
            byte_cnt_d = 4'd0;
            if (Enable) state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (!Enable) begin
               byte_cnt_d = 4'd0;
               state_d    = S_IDLE;
            end else if (done_evt) begin
               word_d[byte_cnt_q*8 +: 8] = RxData;
               if (byte_cnt_q == 4'(WORD_BYTES - 1)) begin
                  byte_cnt_d = 4'd0;
                  state_d    = S_HOLD;
               end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
               end
            end else if (timeout_evt) begin
               byte_cnt_d = 4'd0;
            end
         end
         S_HOLD: begin
            if (accept) begin
               // A byte arriving with the accept starts the next word directly.
               if (done_evt) begin
                  word_d[7:0] = RxData;
                  byte_cnt_d  = 4'd1;
                  state_d     = S_COLLECT;
               end else begin
                  state_d = Enable ? S_COLLECT : S_IDLE;
               end
            end else if (done_evt) begin
               overrun_evt = 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            byte_cnt_d = 4'd0;
         end
      endcase
      overrun_d = (overrun_q & ~ClrErr) | overrun_evt;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 4'd0;
         word_q     <= '0;
         overrun_q  <= 1'b0;
         rxen_q     <= 1'b0;
         rxdone_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         overrun_q  <= overrun_d;
         rxen_q     <= rxen_d;
         rxdone_q   <= rxdone_d;
      end
   end

   assign RxEn      = rxen_q;
   assign NBits     = 4'd8;
   assign WordData  = word_q;
   assign WordValid = (state_q == S_HOLD);
   assign Overrun   = overrun_q;
   assign ByteCnt   = byte_cnt_q;

endmodule

// File: tb/tb_uart_rx_word_ctrl.sv
// Bench for uart_rx_word_ctrl: directed vector table, corner sequences, then random traffic against a queue model.
module tb_uart_rx_word_ctrl;
   localparam int WB = 4;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0, Enable = 1'b0, ClrErr = 1'b0, Tick = 1'b0;
   logic          RxDone = 1'b0, WordReady = 1'b0;
   logic [7:0]    RxData = 8'h00;
   logic          RxEn, WordValid, Overrun, Timeout;
   logic [3:0]    NBits, ByteCnt;
   logic [8*WB-1:0] WordData;

   int tests = 0;
   int fails = 0;

   uart_rx_word_ctrl #(.WORD_BYTES(WB), .TIMEOUT_TICKS(16'd16)) dut (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .ClrErr(ClrErr), .Tick(Tick),
      .RxDone(RxDone), .RxData(RxData), .RxEn(RxEn), .NBits(NBits),
      .WordData(WordData), .WordValid(WordValid), .WordReady(WordReady),
      .Overrun(Overrun), .Timeout(Timeout), .ByteCnt(ByteCnt)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic rst, en, clr, rd;
      logic [7:0] d;
      logic rdy;
      logic ev;
      logic [31:0] edat;
      logic [3:0] ecnt;
      logic erx, eovr;
   } vec_t;
   vec_t vq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      RxData = b; RxDone = 1'b1; cyc();
      RxDone = 1'b0; cyc();
   endtask

   task automatic tick_pulse();
      Tick = 1'b1; cyc();
      Tick = 1'b0; cyc();
   endtask

   // Behavioural reference: current word as a byte queue plus a held-word flag.
   logic [7:0] m_bytes[$];
   logic [7:0] m_lanes[WB];
   bit m_prev_done, m_rxen, m_active, m_held, m_ovr;

   task automatic model_step();
      bit evt, ovr_evt;
      evt = RxDone && !m_prev_done;
      ovr_evt = 0;
      if (Rst) begin
         m_bytes.delete();
         for (int i = 0; i < WB; i++) m_lanes[i] = 8'h00;
         m_prev_done = 0; m_rxen = 0; m_active = 0; m_held = 0; m_ovr = 0;
      end else begin
         if (m_held) begin
            if (WordReady) begin
               m_held = 0;
               if (evt) begin
                  m_lanes[0] = RxData;
                  m_bytes.push_back(RxData);
                  m_active = 1;
               end else begin
                  m_active = Enable;
               end
            end else if (evt) begin
               ovr_evt = 1;
            end
         end else if (!m_active) begin
            if (Enable) m_active = 1;
         end else if (!Enable) begin
            m_active = 0;
            m_bytes.delete();
         end else if (evt) begin
            m_lanes[m_bytes.size()] = RxData;
            m_bytes.push_back(RxData);
            if (m_bytes.size() == WB) begin
               m_bytes.delete();
               m_held = 1;
            end
         end
         m_ovr = (m_ovr && !ClrErr) || ovr_evt;
         m_prev_done = RxDone;
         m_rxen = Enable;
      end
   endtask

   function automatic logic [8*WB-1:0] model_word();
      logic [8*WB-1:0] w;
      for (int i = 0; i < WB; i++) w[i*8 +: 8] = m_lanes[i];
      return w;
   endfunction

   task automatic add_vec(input logic rst, en, clr, rd, input logic [7:0] d, input logic rdy,
                          input logic ev, input logic [31:0] edat, input logic [3:0] ecnt,
                          input logic erx, eovr);
      vec_t v;
      v.rst = rst; v.en = en; v.clr = clr; v.rd = rd; v.d = d; v.rdy = rdy;
      v.ev = ev; v.edat = edat; v.ecnt = ecnt; v.erx = erx; v.eovr = eovr;
      vq.push_back(v);
   endtask

   initial begin
      int vcount;
      logic [31:0] seen;
      logic [31:0] held_word;

      //       rst en clr rd  data  rdy | valid  data          cnt rxen ovr
      add_vec(1, 0, 0, 0, 8'h00, 0,   0, 32'h00000000, 0, 0, 0);
      add_vec(0, 1, 0, 0, 8'h00, 0,   0, 32'h00000000, 0, 1, 0);
      add_vec(0, 1, 0, 1, 8'h11, 0,   0, 32'h00000011, 1, 1, 0);
      add_vec(0, 1, 0, 0, 8'h11, 0,   0, 32'h00000011, 1, 1, 0);
      add_vec(0, 1, 0, 1, 8'h22, 0,   0, 32'h00002211, 2, 1, 0);
      add_vec(0, 1, 0, 0, 8'h22, 0,   0, 32'h00002211, 2, 1, 0);
      add_vec(0, 1, 0, 1, 8'h33, 0,   0, 32'h00332211, 3, 1, 0);
      add_vec(0, 1, 0, 0, 8'h33, 0,   0, 32'h00332211, 3, 1, 0);
      add_vec(0, 1, 0, 1, 8'h44, 0,   1, 32'h44332211, 0, 1, 0);
      add_vec(0, 1, 0, 0, 8'h44, 0,   1, 32'h44332211, 0, 1, 0);
      add_vec(0, 1, 0, 1, 8'h55, 0,   1, 32'h44332211, 0, 1, 1);
      add_vec(0, 1, 0, 0, 8'h55, 0,   1, 32'h44332211, 0, 1, 1);
      add_vec(0, 1, 1, 0, 8'h55, 0,   1, 32'h44332211, 0, 1, 0);
      add_vec(0, 1, 0, 1, 8'h77, 1,   0, 32'h44332277, 1, 1, 0);
      add_vec(0, 1, 0, 0, 8'h77, 0,   0, 32'h44332277, 1, 1, 0);
      add_vec(0, 1, 0, 1, 8'h88, 0,   0, 32'h44338877, 2, 1, 0);
      add_vec(0, 0, 0, 0, 8'h88, 0,   0, 32'h44338877, 0, 0, 0);
      add_vec(0, 0, 0, 0, 8'h88, 0,   0, 32'h44338877, 0, 0, 0);
      add_vec(0, 1, 0, 0, 8'h88, 0,   0, 32'h44338877, 0, 1, 0);
      add_vec(0, 1, 0, 1, 8'h99, 0,   0, 32'h44338899, 1, 1, 0);
      add_vec(1, 1, 0, 0, 8'h99, 0,   0, 32'h00000000, 0, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         Rst = vq[i].rst; Enable = vq[i].en; ClrErr = vq[i].clr;
         RxDone = vq[i].rd; RxData = vq[i].d; WordReady = vq[i].rdy;
         cyc();
         chk($sformatf("vec%0d {valid,data,cnt,rxen,ovr,tmo,nbits}", i),
             {WordValid, WordData, ByteCnt, RxEn, Overrun, Timeout, NBits},
             {vq[i].ev, vq[i].edat, vq[i].ecnt, vq[i].erx, vq[i].eovr, 1'b0, 4'd8});
      end
      Rst = 0; ClrErr = 0; RxDone = 0; WordReady = 0;

      // Long RxDone level counts once; with ready tied high the word is valid one cycle.
      Enable = 1; cyc();
      RxData = 8'hA5; RxDone = 1;
      repeat (5) cyc();
      RxDone = 0; cyc();
      chk("long_rxdone_cnt", ByteCnt, 4'd1);
      WordReady = 1;
      vcount = 0; seen = 32'h0;
      for (int b = 1; b <= 3; b++) begin
         RxData = 8'(b); RxDone = 1; cyc();
         if (WordValid) begin vcount++; seen = WordData; end
         RxDone = 0; cyc();
         if (WordValid) begin vcount++; seen = WordData; end
      end
      repeat (4) begin
         cyc();
         if (WordValid) begin vcount++; seen = WordData; end
      end
      chk("ready_tied_valid_cycles", vcount, 1);
      chk("ready_tied_word", seen, 32'h030201A5);
      WordReady = 0;

      // Overrun set wins over a coincident ClrErr; held word stays put.
      send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
      chk("hold_valid", WordValid, 1'b1);
      held_word = WordData;
      chk("hold_word", held_word, 32'hC4C3C2C1);
      RxData = 8'hEE; RxDone = 1; ClrErr = 1; cyc();
      RxDone = 0; ClrErr = 0;
      chk("ovr_set_beats_clr", Overrun, 1'b1);
      chk("ovr_word_stable", WordData, 32'hC4C3C2C1);
      ClrErr = 1; cyc(); ClrErr = 0;
      chk("ovr_cleared", Overrun, 1'b0);

      // Enable low in HOLD keeps the word; accept then returns to idle.
      Enable = 0; repeat (3) cyc();
      chk("hold_survives_disable", {WordValid, WordData}, {1'b1, 32'hC4C3C2C1});
      WordReady = 1; cyc(); WordReady = 0;
      chk("accept_to_idle_valid", WordValid, 1'b0);
      send_byte(8'h5A);
      chk("idle_ignores_byte", {ByteCnt, RxEn}, {4'd0, 1'b0});
      // A ready pulse with nothing held has no effect.
      Enable = 1; cyc();
      WordReady = 1; cyc(); WordReady = 0;
      send_byte(8'h61);
      chk("stray_ready_ignored", {WordValid, ByteCnt}, {1'b0, 4'd1});

`ifdef UART_RX_WORD_TIMEOUT_EN
      Rst = 1; cyc(); Rst = 0;
      Enable = 1; cyc();
      send_byte(8'h10);
      repeat (15) tick_pulse();
      chk("tmo_before_terminal", {Timeout, ByteCnt}, {1'b0, 4'd1});
      Tick = 1; cyc(); Tick = 0;
      chk("tmo_fires", {Timeout, ByteCnt}, {1'b1, 4'd0});
      cyc();
      ClrErr = 1; cyc(); ClrErr = 0;
      chk("tmo_cleared", Timeout, 1'b0);
      send_byte(8'h20);
      repeat (15) tick_pulse();
      Tick = 1; RxData = 8'h21; RxDone = 1; cyc();
      Tick = 0; RxDone = 0; cyc();
      chk("byte_beats_tmo", {Timeout, ByteCnt, WordData[15:0]}, {1'b0, 4'd2, 16'h2120});
`endif

      // Random traffic against the reference model.
      Tick = 0;
      Rst = 1; ClrErr = 0; RxDone = 0; WordReady = 0; Enable = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c > 0) begin
            Rst = ($urandom_range(0, 199) == 0);
            Enable = ($urandom_range(0, 15) != 0);
            ClrErr = ($urandom_range(0, 15) == 0);
            WordReady = $urandom_range(0, 1);
            if (!RxDone) RxData = 8'($urandom);
            RxDone = ($urandom_range(0, 2) == 0);
         end
         model_step();
         cyc();
         chk($sformatf("rand%0d {valid,data,cnt,rxen,ovr,tmo,nbits}", c),
             {WordValid, WordData, ByteCnt, RxEn, Overrun, Timeout, NBits},
             {m_held, model_word(), 4'(m_bytes.size()), m_rxen, m_ovr, 1'b0, 4'd8});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_word_ctrl.md
Name: uart_rx_word_ctrl

Overview:
Controller for the byte-wide UART receiver.
- Configures the receiver: drives its RxEn and NBits.
- Detects each RxDone, collects WORD_BYTES consecutive bytes into one word and presents it on a valid/ready handshake.
- Sits between the UART receive path and the 32-to-8 address-sort logic. Owns framing, overrun and inter-byte-timeout handling.

Parameters:
- WORD_BYTES, 4, bytes per assembled word (2..8); word width = 8*WORD_BYTES.
- TIMEOUT_TICKS, 16'd640, Tick rising edges allowed between bytes of one word (used only with the optional feature).

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous reset, active-high.
- Enable  input  1  receive enable from host logic.
- ClrErr  input  1  one-cycle pulse; clears sticky error flags.
- Tick  input  1  16x baud tick, level, same clock domain.
- RxDone  input  1  receiver byte-done; may stay high more than 1 Clk.
- RxData  input  8  receiver byte, stable while RxDone high.
- RxEn  output  1  receiver enable.
- NBits  output  4  receiver data-bit count, constant 4'd8.
- WordData  output  8*WORD_BYTES  assembled word; byte 0 in [7:0].
- WordValid  output  1  word available.
- WordReady  input  1  consumer accepts word.
- Overrun  output  1  sticky: byte arrived while a word was held.
- Timeout  output  1  sticky: partial word discarded on timeout (0 when feature off).
- ByteCnt  output  4  bytes collected in current word.

Behaviour:
- Reset (Rst high at a Clk edge) forces every output low except NBits, which stays 4'd8: state=IDLE, ByteCnt=0, WordData=0, Overrun=0, Timeout=0. Internal edge registers clear to 0. Reset mid-word drops the partial word with no flag.
- Byte event: done_evt = RxDone & ~rxdone_q, where rxdone_q is RxDone registered. Exactly one event per RxDone high period.
- Capture: on done_evt, RxData is written to byte lane ByteCnt of WordData.
- RxEn = Enable & (state != IDLE | Enable). That is, RxEn follows Enable, registered, with 1-cycle latency.
- States:
  - IDLE: ByteCnt=0. On Enable=1, go to COLLECT.
  - COLLECT:
    - done_evt with ByteCnt<WORD_BYTES-1: capture, ByteCnt+1.
    - done_evt with ByteCnt=WORD_BYTES-1: capture, ByteCnt=0, go to HOLD, WordValid=1 on the next cycle. Latency is 1 Clk from done_evt.
    - Enable=0: drop partial word, ByteCnt=0, go to IDLE. Receiver disabled.
  - HOLD: WordValid=1 and WordData stable until WordValid&WordReady.
    - On accept: WordValid=0 next cycle. Go to COLLECT if Enable=1, else IDLE.
    - done_evt without accept: byte dropped, Overrun=1, state unchanged.
    - done_evt in the same cycle as accept: byte captured as byte 0 of the next word, ByteCnt=1, go to COLLECT, no overrun.
    - Enable=0 in HOLD does not drop the held word.
- WordReady with WordValid=0 is ignored.
- ClrErr clears Overrun/Timeout. If ClrErr and a new error event occur in the same cycle, the set wins.
- ByteCnt never exceeds WORD_BYTES-1. No wrap beyond the word.

Optional Feature:
Macro UART_RX_WORD_TIMEOUT_EN.
- Defined:
  - A 16-bit tick counter counts Tick rising edges (Tick & ~tick_q) in COLLECT while ByteCnt>0.
  - It clears on every done_evt and whenever ByteCnt=0.
  - When the count reaches TIMEOUT_TICKS: discard the partial word, ByteCnt=0, Timeout=1, stay in COLLECT.
  - If done_evt coincides with the terminal count, the byte wins and there is no timeout.
- Not defined: no counter is built and the Timeout output is tied 0.

Test Plan:
- Reset, then Enable=1; RxDone pulses with bytes 0x11,0x22,0x33,0x44 → one cycle after the 4th event WordValid=1, WordData=32'h44332211, ByteCnt=0, RxEn=1, NBits=8.
- Hold RxDone high for 5 Clk on one byte 0xA5 → ByteCnt increments by exactly 1. With WordReady tied 1 and 4 bytes sent, WordValid is high for exactly 1 cycle.
- WordReady=0 after a full word, 5th byte 0x55 arrives → Overrun=1, WordData unchanged 32'h44332211. ClrErr pulse → Overrun=0.
- In HOLD, WordReady=1 in the same cycle as a done_evt with 0x77 → word accepted, ByteCnt=1, next word [7:0]=0x77, Overrun=0.
- After 2 bytes, drop Enable → ByteCnt=0, state IDLE, RxEn=0 next cycle, no WordValid. Assert Rst during a later partial word → all outputs at reset values.
- With UART_RX_WORD_TIMEOUT_EN and TIMEOUT_TICKS=16: 1 byte, then 16 Tick edges → Timeout=1, ByteCnt=0. A byte on the 16th tick edge → no timeout, ByteCnt=2.
